// File: rtl/inst_decode.sv
// MIPS-I decode stage: IF/ID register, field decode, branch/jump resolution, load-use stall, ID/EX register.
// Defining DECODE_RI_TRAP_EN enables the reserved-instruction flag ri_exc.
module inst_decode #(
  parameter logic [31:0] NOP_INST = 32'h00000000,
  parameter logic [4:0]  LINK_REG = 5'd31
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst,
  input  logic [29:0] pc,
  input  logic        stall_in,
  input  logic        ex_load,
  input  logic [4:0]  ex_load_rd,
  output logic [4:0]  rs_addr,
  output logic [4:0]  rt_addr,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        stall_out,
  output logic        jump,
  output logic [29:0] jump_pc,
  output logic        ex_valid,
  output logic [31:0] ex_inst,
  output logic [29:0] ex_pc,
  output logic [31:0] ex_rs_val,
  output logic [31:0] ex_rt_val,
  output logic [31:0] ex_imm,
  output logic [4:0]  ex_dst,
  output logic [31:0] ex_link_val,
  output logic        ri_exc
);

  typedef enum logic [3:0] {
    C_UNK, C_RTYPE, C_JR, C_JALR, C_J, C_JAL,
    C_BR_CMP, C_BR_ZERO, C_REGIMM, C_ALUI, C_LOAD, C_STORE
  } inst_class_e;

  logic [31:0] id_inst_q, id_inst_d;
  logic [29:0] id_pc_q, id_pc_d;
  logic        ex_valid_q, ex_valid_d;
  logic [31:0] ex_inst_q, ex_inst_d;
  logic [29:0] ex_pc_q, ex_pc_d;
  logic [31:0] ex_rs_val_q, ex_rs_val_d;
  logic [31:0] ex_rt_val_q, ex_rt_val_d;
  logic [31:0] ex_imm_q, ex_imm_d;
  logic [4:0]  ex_dst_q, ex_dst_d;
  logic [31:0] ex_link_val_q, ex_link_val_d;

  inst_class_e cls;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd;
  logic        uses_rs, uses_rt, hazard, taken;
  logic [31:0] imm_sext, imm_ext;
  logic [4:0]  dst;
  logic [29:0] pc_inc, target;

  assign opcode   = id_inst_q[31:26];
  assign rs       = id_inst_q[25:21];
  assign rt       = id_inst_q[20:16];
  assign rd       = id_inst_q[15:11];
  assign funct    = id_inst_q[5:0];
  assign imm_sext = {{16{id_inst_q[15]}}, id_inst_q[15:0]};
  assign pc_inc   = id_pc_q + 30'd1;

  always_comb begin
    cls = C_UNK;
    case (opcode)
      6'h00: begin
        case (funct)
          6'h08: cls = C_JR;
          6'h09: cls = C_JALR;
          6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h0C, 6'h0D,
          6'h10, 6'h11, 6'h12, 6'h13, 6'h18, 6'h19, 6'h1A, 6'h1B,
          6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
          6'h2A, 6'h2B: cls = C_RTYPE;
          default: cls = C_UNK;
        endcase
      end
      6'h01: begin
        if (rt == 5'h00 || rt == 5'h01 || rt == 5'h10 || rt == 5'h11) cls = C_REGIMM;
      end
      6'h02: cls = C_J;
      6'h03: cls = C_JAL;
      6'h04, 6'h05: cls = C_BR_CMP;
      6'h06, 6'h07: cls = C_BR_ZERO;
      6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F: cls = C_ALUI;
      6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26: cls = C_LOAD;
      6'h28, 6'h29, 6'h2A, 6'h2B, 6'h2E: cls = C_STORE;
      default: cls = C_UNK;
    endcase
  end

  // Unknown encodings behave as NOP: no operands, no destination, no redirect.
  always_comb begin
    uses_rs = !(cls inside {C_J, C_JAL, C_UNK});
    uses_rt = !(cls inside {C_J, C_JAL, C_UNK, C_ALUI, C_LOAD});

    case (opcode)
      6'h0C, 6'h0D, 6'h0E: imm_ext = {16'h0000, id_inst_q[15:0]};
      6'h0F:               imm_ext = {id_inst_q[15:0], 16'h0000};
      default:             imm_ext = imm_sext;
    endcase

    dst = 5'd0;
    case (cls)
      C_RTYPE, C_JALR: dst = rd;
      C_ALUI, C_LOAD:  dst = rt;
      C_JAL:           dst = LINK_REG;
      C_REGIMM:        dst = rt[4] ? LINK_REG : 5'd0;
      default:         dst = 5'd0;
    endcase

    taken  = 1'b0;
    target = 30'd0;
    case (cls)
      C_J, C_JAL: begin
        taken  = 1'b1;
        target = {pc_inc[29:26], id_inst_q[25:0]};
      end
      C_JR, C_JALR: begin
        taken  = 1'b1;
        target = rs_val[31:2];
      end
      C_BR_CMP: begin
        taken  = opcode[0] ? (rs_val != rt_val) : (rs_val == rt_val);
        target = taken ? pc_inc + imm_sext[29:0] : pc_inc;
      end
      C_BR_ZERO: begin
        taken  = opcode[0] ? ($signed(rs_val) > 32'sd0) : ($signed(rs_val) <= 32'sd0);
        target = taken ? pc_inc + imm_sext[29:0] : pc_inc;
      end
      C_REGIMM: begin
        taken  = rt[0] ? !rs_val[31] : rs_val[31];
        target = taken ? pc_inc + imm_sext[29:0] : pc_inc;
      end
      default: begin
        taken  = 1'b0;
        target = 30'd0;
      end
    endcase
  end

  assign hazard = ex_load && (ex_load_rd != 5'd0) &&
                  ((uses_rs && ex_load_rd == rs) || (uses_rt && ex_load_rd == rt));
  assign stall_out = stall_in | hazard;
  // A branch held by a stall redirects only once the stall releases.
  assign jump      = taken & ~stall_out;
  assign jump_pc   = target;
  assign rs_addr   = rs;
  assign rt_addr   = rt;

`ifdef DECODE_RI_TRAP_EN
  logic ri_exc_q, ri_exc_d;
  assign ri_exc = ri_exc_q;
`else
  assign ri_exc = 1'b0;
`endif

  always_comb begin
    id_inst_d     = id_inst_q;
    id_pc_d       = id_pc_q;
    ex_valid_d    = ex_valid_q;
    ex_inst_d     = ex_inst_q;
    ex_pc_d       = ex_pc_q;
    ex_rs_val_d   = ex_rs_val_q;
    ex_rt_val_d   = ex_rt_val_q;
    ex_imm_d      = ex_imm_q;
    ex_dst_d      = ex_dst_q;
    ex_link_val_d = ex_link_val_q;
`ifdef DECODE_RI_TRAP_EN
    ri_exc_d      = ri_exc_q;
`endif
    if (!stall_out) begin
      id_inst_d = inst;
      id_pc_d   = pc;
    end
    if (!stall_in) begin
      if (hazard) begin
        ex_valid_d = 1'b0;
        ex_inst_d  = NOP_INST;
        ex_dst_d   = 5'd0;
`ifdef DECODE_RI_TRAP_EN
        ri_exc_d   = 1'b0;
`endif
      end else begin
        ex_valid_d    = 1'b1;
        ex_inst_d     = id_inst_q;
        ex_pc_d       = id_pc_q;
        ex_rs_val_d   = rs_val;
        ex_rt_val_d   = rt_val;
        ex_imm_d      = imm_ext;
        ex_dst_d      = dst;
        ex_link_val_d = {id_pc_q + 30'd2, 2'b00};
`ifdef DECODE_RI_TRAP_EN
        ri_exc_d      = (cls == C_UNK);
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      id_inst_q     <= NOP_INST;
      id_pc_q       <= 30'd0;
      ex_valid_q    <= 1'b0;
      ex_inst_q     <= 32'd0;
      ex_pc_q       <= 30'd0;
      ex_rs_val_q   <= 32'd0;
      ex_rt_val_q   <= 32'd0;
      ex_imm_q      <= 32'd0;
      ex_dst_q      <= 5'd0;
      ex_link_val_q <= 32'd0;
`ifdef DECODE_RI_TRAP_EN
      ri_exc_q      <= 1'b0;
`endif
    end else begin
      id_inst_q     <= id_inst_d;
      id_pc_q       <= id_pc_d;
      ex_valid_q    <= ex_valid_d;
      ex_inst_q     <= ex_inst_d;
      ex_pc_q       <= ex_pc_d;
      ex_rs_val_q   <= ex_rs_val_d;
      ex_rt_val_q   <= ex_rt_val_d;
      ex_imm_q      <= ex_imm_d;
      ex_dst_q      <= ex_dst_d;
      ex_link_val_q <= ex_link_val_d;
`ifdef DECODE_RI_TRAP_EN
      ri_exc_q      <= ri_exc_d;
`endif
    end
  end

  assign ex_valid    = ex_valid_q;
  assign ex_inst     = ex_inst_q;
  assign ex_pc       = ex_pc_q;
  assign ex_rs_val   = ex_rs_val_q;
  assign ex_rt_val   = ex_rt_val_q;
  assign ex_imm      = ex_imm_q;
  assign ex_dst      = ex_dst_q;
  assign ex_link_val = ex_link_val_q;

endmodule

// File: doc/inst_decode.md
Name: inst_decode

Overview:
- Decode stage that sits directly downstream of instruction fetch.
- Holds the IF/ID pipeline register, decodes MIPS-I fields and reads register-file operands.
- Resolves branches and jumps in ID, with one architectural delay slot, and drives jump/jump_pc back to fetch.
- Detects load-use hazards and produces the registered ID/EX bundle for execute.

Parameters:
NOP_INST, 32'h00000000, instruction word injected as a bubble
LINK_REG, 31, destination register for JAL/BLTZAL/BGEZAL

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, asynchronous, active-low
inst  in  32  instruction from fetch (0 when fetch not ready)
pc  in  30  word address [31:2] of inst
stall_in  in  1  execute/memory cannot accept a new bundle
ex_load  in  1  instruction currently in EX is a load
ex_load_rd  in  5  destination of that load
rs_addr  out  5  regfile read port A address (comb. from id_inst[25:21])
rt_addr  out  5  regfile read port B address (comb. from id_inst[20:16])
rs_val  in  32  port A data, already forwarded
rt_val  in  32  port B data, already forwarded
stall_out  out  1  stall to fetch
jump  out  1  redirect fetch this cycle
jump_pc  out  30  redirect word address
ex_valid  out  1  ID/EX bundle valid
ex_inst  out  32  instruction
ex_pc  out  30  its word address
ex_rs_val  out  32  operand A
ex_rt_val  out  32  operand B
ex_imm  out  32  extended immediate
ex_dst  out  5  destination register (0 = none)
ex_link_val  out  32  return byte address for link instructions
ri_exc  out  1  reserved-instruction flag (see optional feature)

Behaviour:
- Reset (rst=0, async) clears all state:
  - id_inst=NOP_INST, id_pc=0.
  - All ex_* outputs = 0, ex_valid=0.
  - ri_exc=0.
  - jump and stall_out evaluate to 0 from the reset state.
- Load-use hazard:
  - hazard = ex_load & ex_load_rd≠0 & (ex_load_rd==rs when rs is used | ex_load_rd==rt when rt is used).
  - rs/rt usage comes from the opcode: rt is unused for I-type ALU ops and loads; both are unused for J/JAL.
- stall_out = stall_in | hazard.
- IF/ID register, on each edge:
  - If stall_out=0: id_inst<=inst, id_pc<=pc.
  - Otherwise: hold.
- ID/EX register, on each edge:
  - stall_in=1: hold everything.
  - Else if hazard=1: insert a bubble (ex_valid<=0, ex_inst<=NOP_INST, ex_dst<=0).
  - Else: load the decoded bundle, ex_valid<=1.
- Immediate extension:
  - Sign-extend for arithmetic, loads/stores and branches.
  - Zero-extend for ANDI/ORI/XORI.
  - LUI gives {imm16,16'h0}.
- Destination (ex_dst):
  - R-type: rd.
  - I-type writes: rt.
  - JAL, BLTZAL, BGEZAL: LINK_REG.
  - JALR: rd.
  - Stores, branches, J, JR: 0.
- ex_link_val = {id_pc+2, 2'b00}, i.e. the address after the delay slot, mod 2^32.
- jump (combinational) is asserted only when stall_out=0 and id_inst is a taken control transfer:
  - J/JAL: jump_pc = {(id_pc+1)[31:28], id_inst[25:0]}.
  - JR/JALR: jump_pc = rs_val[31:2]; low 2 bits are ignored.
  - BEQ/BNE/BLEZ/BGTZ/BLTZ/BGEZ(+AL): compare rs_val/rt_val as signed 32-bit; jump_pc = id_pc + 1 + sext30(imm16), 30-bit wrap-around.
  - Not-taken branch: jump=0, jump_pc = don't-care (drive id_pc+1).
- Delay slot: the instruction fetched in the same cycle the branch is in ID is the delay slot. It is always passed on, never squashed.
- If a stall arrives while a branch sits in ID: the branch is held and jump is re-evaluated when the stall releases, so exactly one redirect is issued.
- Reset asserted mid-operation: all in-flight state is dropped, no redirect is issued, and the first post-reset cycle decodes NOP.

Optional Feature:
DECODE_RI_TRAP_EN
- Defined:
  - An unrecognised opcode/funct in ID sets ri_exc=1 together with ex_valid=1 in the ID/EX bundle, with ex_dst forced to 0.
  - ri_exc follows the ID/EX hold/bubble rules.
- Undefined:
  - ri_exc is tied to 0.
  - Unknown encodings decode as NOP (ex_dst=0, no jump).

Test Plan:
1. Reset release, inst=0 stream -> ex_valid=1 from 2nd edge, ex_dst=0, jump never high; while rst=0 all outputs remain 0.
2. ADDIU $3,$0,-1 (0x2403FFFF) at pc=0x10 -> one cycle later ex_imm=0xFFFFFFFF, ex_dst=3, ex_pc=0x10.
3. BEQ $1,$2,+4 at pc=0x20, rs_val=rt_val=5 -> jump=1, jump_pc=0x25. Delay slot at 0x21 reaches EX; with rt_val=6, jump=0.
4. JAL 0x0100000 at id_pc=0x3FFFFFFF -> jump_pc=0x00100000 (upper bits from the wrapped pc+1 = 0), ex_dst=31, ex_link_val=0x00000004.
5. LW $4 in EX (ex_load=1, ex_load_rd=4) while ADDU $5,$4,$4 in ID -> stall_out=1 for 1 cycle, one bubble (ex_valid=0), then ADDU issues; a hazard with ex_load_rd=0 must not stall.
6. JR $31 in ID with stall_in=1 for 3 cycles -> jump=0 throughout, jump=1 with jump_pc=rs_val[31:2] exactly once on release; with DECODE_RI_TRAP_EN, opcode 0x3F -> ri_exc=1.
